// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle for rf_write_arbiter: pipeline writeback request, MDU result
// handshake and the registered register-file write port.
interface rf_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_wdata;
  logic              pipe_stall;

  logic              mdu_valid;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_rd;
  logic [DATA_W-1:0] mdu_wdata;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Requesters: pipeline WB stage and MDU.
  modport master (
    output pipe_we, pipe_rd, pipe_wdata, mdu_valid, mdu_rd, mdu_wdata,
    input  pipe_stall, mdu_ready, rf_we, rf_waddr, rf_wdata
  );

  // Arbiter.
  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata, mdu_valid, mdu_rd, mdu_wdata,
    output pipe_stall, mdu_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs. buffered MDU results with an
// anti-starvation age counter and pending-write lookup. Optional RF_ARB_STATS_EN.
module rf_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  rf_write_arbiter_if.slave      bus,
  input  logic [ADDR_W-1:0]      q_rs,
  input  logic [ADDR_W-1:0]      q_rt,
  output logic                   rs_pending,
  output logic                   rt_pending,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]            stall_cycles,
  output logic [15:0]            full_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [AGE_W-1:0]   age;

  entry_t head;
  logic   pipe_req;
  logic   fifo_nonempty;
  logic   head_aged;
  logic   grant_mdu;
  logic   grant_pipe;
  logic   accept;
  logic   push;
  logic   rs_hit;
  logic   rt_hit;

  assign head = mem[rd_ptr];

  always_comb begin
    pipe_req      = bus.pipe_we && (bus.pipe_rd != '0);
    fifo_nonempty = (fifo_count != '0);
    head_aged     = (age == AGE_W'(MAX_WAIT));
    // The FIFO head wins an idle slot, or steals the slot once it has aged out.
    grant_mdu     = !reset && fifo_nonempty && (!pipe_req || head_aged);
    grant_pipe    = !reset && pipe_req && !grant_mdu;
    accept        = bus.mdu_valid && bus.mdu_ready;
    // A result for $0 completes the handshake but is dropped.
    push          = accept && (bus.mdu_rd != '0);
  end

  assign bus.mdu_ready  = !reset && (fifo_count < CNT_W'(DEPTH));
  assign bus.pipe_stall = grant_mdu && pipe_req;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      valid      <= '0;
      fifo_count <= '0;
      age        <= '0;
    end else begin
      if (grant_mdu) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + PTR_W'(1);
        valid[wr_ptr] <= 1'b1;
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(grant_mdu);
      if (!fifo_nonempty || grant_mdu) begin
        age <= '0;
      end else if (!head_aged) begin
        age <= age + AGE_W'(1);
      end
    end
  end

  // NOTE: payload storage has no reset; the per-slot valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{rd: bus.mdu_rd, data: bus.mdu_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= grant_mdu || grant_pipe;
      if (grant_mdu) begin
        bus.rf_waddr <= head.rd;
        bus.rf_wdata <= head.data;
      end else if (grant_pipe) begin
        bus.rf_waddr <= bus.pipe_rd;
        bus.rf_wdata <= bus.pipe_wdata;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].rd == q_rs)) rs_hit = 1'b1;
      if (valid[i] && (mem[i].rd == q_rt)) rt_hit = 1'b1;
    end
    // The register being written this cycle is still in flight for readers.
    rs_pending = !reset && (q_rs != '0) &&
                 (rs_hit || (bus.rf_we && (bus.rf_waddr == q_rs)));
    rt_pending = !reset && (q_rt != '0) &&
                 (rt_hit || (bus.rf_we && (bus.rf_waddr == q_rt)));
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      full_cycles  <= '0;
    end else begin
      if (bus.pipe_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 16'd1;
      if ((fifo_count == CNT_W'(DEPTH)) && (full_cycles != '1)) full_cycles <= full_cycles + 16'd1;
    end
  end
`else
  // Statistics counters are not built; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: stimulus queues expected rf writes with their
// arrival cycle, a negedge monitor pops and compares each rf_we pulse.
module tb_rf_write_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [ADDR_W-1:0]      q_rs;
  logic [ADDR_W-1:0]      q_rt;
  logic                   rs_pending;
  logic                   rt_pending;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef RF_ARB_STATS_EN
  logic [15:0]            stall_cycles;
  logic [15:0]            full_cycles;
`endif

  rf_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rf_write_arbiter #(
    .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .q_rs       (q_rs),
    .q_rt       (q_rt),
    .rs_pending (rs_pending),
    .rt_pending (rt_pending),
    .fifo_count (fifo_count)
`ifdef RF_ARB_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .full_cycles  (full_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.pipe_we   = 1'b0;
    bus.mdu_valid = 1'b0;
  endtask

  // Monitor: every rf write must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.rf_we), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rf_waddr", 32'(bus.rf_waddr), 32'(mon_e.addr));
        check("rf_wdata", 32'(bus.rf_wdata), 32'(mon_e.data));
        check("rf_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset with live requests on the inputs: nothing may be accepted or flagged.
    reset          = 1'b1;
    bus.pipe_we    = 1'b1;
    bus.pipe_rd    = 5'd4;
    bus.pipe_wdata = 32'h44;
    bus.mdu_valid  = 1'b1;
    bus.mdu_rd     = 5'd3;
    bus.mdu_wdata  = 32'h33;
    q_rs           = 5'd3;
    q_rt           = 5'd4;
    repeat (2) @(posedge clk);
    mid();
    check("rst_mdu_ready",  32'(bus.mdu_ready),  32'd0);
    check("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
    check("rst_rs_pending", 32'(rs_pending),     32'd0);
    check("rst_rf_we",      32'(bus.rf_we),      32'd0);
    check("rst_fifo_count", 32'(fifo_count),     32'd0);
    tick();
    reset = 1'b0;
    drive_idle();
    mid();
    check("post_rst_ready", 32'(bus.mdu_ready), 32'd1);
    check("post_rst_count", 32'(fifo_count),    32'd0);
    check("post_rst_rf_we", 32'(bus.rf_we),     32'd0);

    // Pipe-only write lands one cycle later.
    tick();
    bus.pipe_we    = 1'b1;
    bus.pipe_rd    = 5'd5;
    bus.pipe_wdata = 32'h1234;
    q_rs           = 5'd5;
    expect_write(5'd5, 32'h1234, cyc + 1);
    mid();
    check("t1_stall",     32'(bus.pipe_stall), 32'd0);
    check("t1_rs_before", 32'(rs_pending),     32'd0);
    tick();
    drive_idle();
    mid();
    check("t1_rs_at_rf", 32'(rs_pending), 32'd1);
    tick();
    mid();
    check("t1_rs_after", 32'(rs_pending), 32'd0);

    // MDU result into an idle slot: rf write two cycles after acceptance.
    tick();
    n              = cyc;
    q_rs           = 5'd7;
    bus.mdu_valid  = 1'b1;
    bus.mdu_rd     = 5'd7;
    bus.mdu_wdata  = 32'hBEEF;
    expect_write(5'd7, 32'hBEEF, n + 2);
    mid();
    check("t2_ready",   32'(bus.mdu_ready), 32'd1);
    check("t2_pend_c0", 32'(rs_pending),    32'd0);
    tick();
    drive_idle();
    mid();
    check("t2_pend_c1",  32'(rs_pending), 32'd1);
    check("t2_count_c1", 32'(fifo_count), 32'd1);
    tick();
    mid();
    check("t2_pend_c2",  32'(rs_pending), 32'd1);
    check("t2_count_c2", 32'(fifo_count), 32'd0);
    tick();
    mid();
    check("t2_pend_c3", 32'(rs_pending), 32'd0);

    // Starvation guard: pipe wins three times, then one stall cycle for the MDU head.
    tick();
    for (int k = 0; k < 6; k++) begin
      bus.pipe_we    = 1'b1;
      bus.pipe_rd    = 5'd10;
      bus.pipe_wdata = 32'hA0 + 32'((k == 5) ? 4 : k);
      bus.mdu_valid  = (k == 0);
      bus.mdu_rd     = 5'd9;
      bus.mdu_wdata  = 32'h900D;
      if (k == 4) expect_write(5'd9, 32'h900D, cyc + 1);
      else        expect_write(5'd10, bus.pipe_wdata, cyc + 1);
      mid();
      check($sformatf("t3_stall_k%0d", k), 32'(bus.pipe_stall), 32'(k == 4));
      tick();
    end
    drive_idle();
    mid();
    check("t3_count_end", 32'(fifo_count), 32'd0);

    // Fill to DEPTH under pipe pressure, backpressure a fifth result, drain in order.
    tick();
    q_rt = 5'd15;
    for (int k = 0; k < 10; k++) begin
      bus.pipe_we    = (k <= 5);
      bus.pipe_rd    = 5'd11;
      bus.pipe_wdata = 32'h500 + 32'((k <= 4) ? k : 4);
      bus.mdu_valid  = (k <= 5);
      bus.mdu_rd     = 5'(12 + ((k <= 4) ? k : 4));
      bus.mdu_wdata  = 32'h4D00 + 32'(bus.mdu_rd);
      if (k <= 3 || k == 5) expect_write(5'd11, bus.pipe_wdata, cyc + 1);
      else if (k == 4)      expect_write(5'd12, 32'h4D0C, cyc + 1);
      else                  expect_write(5'(13 + k - 6), 32'h4D00 + 32'(13 + k - 6), cyc + 1);
      mid();
      if (k == 4) begin
        check("t4_full_ready", 32'(bus.mdu_ready),  32'd0);
        check("t4_full_count", 32'(fifo_count),     32'd4);
        check("t4_full_stall", 32'(bus.pipe_stall), 32'd1);
        check("t4_rt_pending", 32'(rt_pending),     32'd1);
      end else if (k == 5) begin
        check("t4_pop_ready", 32'(bus.mdu_ready),  32'd1);
        check("t4_pop_count", 32'(fifo_count),     32'd3);
        check("t4_pop_stall", 32'(bus.pipe_stall), 32'd0);
      end
      tick();
    end
    drive_idle();
    mid();
    check("t4_drained", 32'(fifo_count), 32'd0);

    // Writes to $0 are swallowed on both sides.
    tick();
    q_rs           = 5'd0;
    bus.pipe_we    = 1'b1;
    bus.pipe_rd    = 5'd0;
    bus.pipe_wdata = 32'hDEAD;
    bus.mdu_valid  = 1'b1;
    bus.mdu_rd     = 5'd0;
    bus.mdu_wdata  = 32'hCAFE;
    mid();
    check("t5_stall", 32'(bus.pipe_stall), 32'd0);
    check("t5_ready", 32'(bus.mdu_ready),  32'd1);
    check("t5_rs0",   32'(rs_pending),     32'd0);
    tick();
    drive_idle();
    mid();
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_rf_we", 32'(bus.rf_we),  32'd0);
    check("t5_rs0_b", 32'(rs_pending), 32'd0);

    // Mid-operation reset with three queued results.
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.pipe_we    = 1'b1;
      bus.pipe_rd    = 5'd11;
      bus.pipe_wdata = 32'h600 + 32'(k);
      bus.mdu_valid  = 1'b1;
      bus.mdu_rd     = 5'(20 + k);
      bus.mdu_wdata  = 32'h6D00 + 32'(k);
      expect_write(5'd11, bus.pipe_wdata, cyc + 1);
      mid();
      check($sformatf("t6_stall_k%0d", k), 32'(bus.pipe_stall), 32'd0);
      tick();
    end
    drive_idle();
    reset = 1'b1;
    q_rs  = 5'd20;
    q_rt  = 5'd21;
    mid();
    check("t6_pre_count", 32'(fifo_count),     32'd3);
    check("t6_rst_ready", 32'(bus.mdu_ready),  32'd0);
    check("t6_rst_stall", 32'(bus.pipe_stall), 32'd0);
    check("t6_rst_rs",    32'(rs_pending),     32'd0);
    check("t6_rst_rt",    32'(rt_pending),     32'd0);
    tick();
    reset = 1'b0;
    mid();
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_rf_we", 32'(bus.rf_we),  32'd0);
    check("t6_rs",    32'(rs_pending), 32'd0);
    check("t6_rt",    32'(rt_pending), 32'd0);
    repeat (6) tick();
    mid();
    check("t6_rs_late", 32'(rs_pending), 32'd0);

    repeat (2) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Arbitrates the register file's single write port between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU).
MDU results are buffered in a small FIFO. Pipeline writes normally take priority. An age counter on the FIFO head prevents starvation by stalling the pipeline for one cycle.
The block also exports a pending-write scoreboard lookup, which the hazard unit uses to stall readers of registers whose values are still in flight.

Parameters:
DEPTH, 4, MDU result FIFO entries; power of 2, >=2
MAX_WAIT, 3, cycles the FIFO head may be denied before it forces a grant; >=1
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  reset, synchronous, active-high
pipe_we  in  1  pipeline WB write request
pipe_rd  in  ADDR_W  pipeline WB destination
pipe_wdata  in  DATA_W  pipeline WB data
pipe_stall  out  1  pipeline must hold WB this cycle (combinational)
mdu_valid  in  1  MDU result valid
mdu_ready  out  1  FIFO can accept an MDU result
mdu_rd  in  ADDR_W  MDU destination
mdu_wdata  in  DATA_W  MDU result
q_rs  in  ADDR_W  scoreboard query A
q_rt  in  ADDR_W  scoreboard query B
rs_pending  out  1  q_rs has an in-flight write
rt_pending  out  1  q_rt has an in-flight write
rf_we  out  1  registered write enable to register file
rf_waddr  out  ADDR_W  registered write address
rf_wdata  out  DATA_W  registered write data
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Request qualification:
  - pipe_req = pipe_we && pipe_rd!=0.
  - pipe_we with pipe_rd==0 is consumed silently: no write, no stall.
- MDU handshake:
  - mdu_ready = !reset && fifo_count<DEPTH. mdu_ready does not depend on a same-cycle pop.
  - A push occurs when mdu_valid && mdu_ready.
  - An MDU push with mdu_rd==0 is accepted but not enqueued.
- Head age counter:
  - Clears when the FIFO is empty or the head is popped.
  - Otherwise increments each cycle the head is valid and not granted.
  - Saturates at MAX_WAIT.
- Grant, evaluated each cycle:
  - If the FIFO is non-empty and (!pipe_req or age==MAX_WAIT): the FIFO head is granted and popped, and pipe_stall = pipe_req.
  - Else if pipe_req: the pipeline is granted and pipe_stall=0.
  - Else: no grant.
- While stalled, the pipeline holds pipe_we/pipe_rd/pipe_wdata unchanged. The arbiter keeps no copy of the stalled write.
- Output register:
  - Next-cycle rf_we=1 with the granted address/data.
  - rf_we=0 when there is no grant. rf_waddr/rf_wdata hold their last values when rf_we=0.
- Latency:
  - Pipeline write: at rf port 1 cycle after the grant.
  - MDU write: at rf port no earlier than 2 cycles after acceptance. There is no bypass of an empty FIFO.
- Simultaneous push and pop with fifo_count<DEPTH: count unchanged and ordering preserved. When full, only the pop occurs.
- Pointers wrap modulo DEPTH. fifo_count distinguishes full from empty.
- Scoreboard:
  - rs_pending = q_rs!=0 && (any valid FIFO entry rd==q_rs, or rf_we && rf_waddr==q_rs). rt_pending is identical for q_rt.
  - Purely combinational.
- WAW hazards between the pipeline and the MDU are not reordered by this block. The hazard unit prevents them using the pending flags.
- Reset, including mid-operation:
  - FIFO flushed, count and age set to 0.
  - rf_we/rf_waddr/rf_wdata set to 0.
  - pipe_stall, mdu_ready, rs_pending and rt_pending are 0 while reset is high.
  - In-flight MDU entries are discarded.

Optional Feature:
RF_ARB_STATS_EN:
- Defined: adds outputs stall_cycles[15:0] and full_cycles[15:0].
  - Saturating counters of cycles with pipe_stall=1 and with fifo_count==DEPTH.
  - Cleared by reset.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical.

Test Plan:
1. Pipe-only write: pipe_we=1, rd=5, data=0x1234 for 1 cycle, FIFO empty -> next cycle rf_we=1, waddr=5, wdata=0x1234; pipe_stall stays 0.
2. Idle slot: push MDU rd=7, data=0xBEEF with pipe idle -> rf_we=1 with waddr=7 exactly 2 cycles after the push; rs_pending=1 for q_rs=7 from the cycle after the push until the cycle after the rf write.
3. Starvation guard: enqueue MDU rd=9 with pipe_req held continuously, MAX_WAIT=3 -> pipe wins 3 cycles; on the 4th cycle FIFO granted and pipe_stall=1 for exactly one cycle; the held pipe write lands on the following cycle.
4. Fill and backpressure: push 4 MDU results while pipe_req stays high -> mdu_ready=0 at count 4; a 5th mdu_valid is not accepted until a pop; results leave in push order.
5. $0 writes: pipe rd=0 and MDU rd=0 -> rf_we never asserted, fifo_count unchanged, q_rs=0 never pending.
6. Mid-operation reset: FIFO holding 3 entries, assert reset 1 cycle -> fifo_count=0, rf_we=0, pending flags 0, and no queued entry ever reaches the rf port afterwards.
